free_list_ckpt: RTL and testbench

Parametrised physical-register free list for the rename stage, successor to the fixed 4-way/64-entry free list. It hands out up to WAYS free physical registers per cycle to the RAT and tracks a speculative and a committed free vector. It adds NCKPT branch checkpoints for single-cycle recovery to a mispredicted branch, besides full flush to committed state. It sits between the RAT (allocation), the RRAT/ROB (retire frees) and branch resolution (checkpoint take/restore).

---
 rtl/freelist_pkg.sv | 18 +
 rtl/free_pick.sv | 28 ++
 rtl/free_list_ckpt.sv | 144 ++++++++++++++
 tb/tb_free_list_ckpt.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freelist_pkg.sv
// Shared sizing defaults and types for the rename-stage physical-register free list.
package freelist_pkg;

  localparam int WAYS    = 4;
  localparam int PRF     = 64;
  localparam int ARF     = 32;
  localparam int NCKPT   = 4;

  localparam int PRF_W   = $clog2(PRF);
  localparam int TAG_W   = $clog2(NCKPT);
  localparam int CNT_W   = $clog2(PRF + 1);
  localparam int AVAIL_W = $clog2(WAYS + 1);

  typedef logic [PRF_W-1:0] preg_t;
  typedef logic [TAG_W-1:0] ckpt_tag_t;
  typedef logic [PRF-1:0]   free_vec_t;

endpackage

// File: rtl/free_pick.sv
// Finds the lowest WAYS set bits of a free vector and how many were found (saturating at WAYS).
module free_pick #(
  parameter int WAYS = freelist_pkg::WAYS,
  parameter int PRF  = freelist_pkg::PRF
) (
  input  logic [PRF-1:0]                    free_vec,
  output logic [WAYS-1:0][$clog2(PRF)-1:0]  idx,
  output logic [$clog2(WAYS+1)-1:0]         found
);

  localparam int PRF_W = $clog2(PRF);
  localparam int AV_W  = $clog2(WAYS + 1);

  always_comb begin
    // NOTE: every output gets a default before the scan; lanes left unfilled would otherwise infer latches.
    idx   = '0;
    found = '0;
    for (int b = 0; b < PRF; b++) begin
      if (free_vec[b] && (found < AV_W'(WAYS))) begin
        for (int k = 0; k < WAYS; k++) begin
          if (found == AV_W'(k)) idx[k] = PRF_W'(b);
        end
        found = found + AV_W'(1);
      end
    end
  end

endmodule

// File: rtl/free_list_ckpt.sv
// Checkpointed physical-register free list. Define FREELIST_CKPT_EN to build snapshot
// storage and take/restore; without it only flush recovers and the checkpoint ports are ignored.
module free_list_ckpt #(
  parameter int WAYS  = freelist_pkg::WAYS,
  parameter int PRF   = freelist_pkg::PRF,
  parameter int ARF   = freelist_pkg::ARF,
  parameter int NCKPT = freelist_pkg::NCKPT
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [WAYS-1:0]                   alloc_req,
  output logic [WAYS-1:0][$clog2(PRF)-1:0]  alloc_idx,
  output logic [WAYS-1:0]                   alloc_valid,
  output logic [$clog2(WAYS+1)-1:0]         avail,
  input  logic [WAYS-1:0][$clog2(PRF)-1:0]  ret_new_idx,
  input  logic [WAYS-1:0]                   ret_new_en,
  input  logic [WAYS-1:0][$clog2(PRF)-1:0]  ret_old_idx,
  input  logic [WAYS-1:0]                   ret_old_en,
  input  logic                              flush,
  input  logic                              ckpt_take,
  input  logic [$clog2(NCKPT)-1:0]          ckpt_tag,
  input  logic [$clog2(WAYS+1)-1:0]         ckpt_lane,
  input  logic                              ckpt_restore,
  input  logic [$clog2(NCKPT)-1:0]          restore_tag
);

  localparam int PRF_W = $clog2(PRF);
  localparam int CNT_W = $clog2(PRF + 1);
  localparam int AV_W  = $clog2(WAYS + 1);

  typedef logic [PRF-1:0] vec_t;

  // Architectural registers 0..ARF-1 hold the initial mapping; the rest start free.
  localparam vec_t RESET_FREE = {{(PRF-ARF){1'b1}}, {ARF{1'b0}}};

  vec_t                       spec_free, com_free;
  vec_t                       spec_nxt, com_nxt;
  vec_t                       grant_mask, free_mask, new_mask;
  logic [CNT_W-1:0]           free_cnt, cnt_nxt;
  logic [WAYS-1:0][PRF_W-1:0] pick_idx;
  logic [AV_W-1:0]            pick_found;
  logic                       restore_hit;
  logic                       recover_blk;
  vec_t                       restore_vec;

  function automatic vec_t onehot(input logic [PRF_W-1:0] i);
    return vec_t'(1) << i;
  endfunction

  free_pick #(.WAYS(WAYS), .PRF(PRF)) u_pick (
    .free_vec (spec_free),
    .idx      (pick_idx),
    .found    (pick_found)
  );

  assign alloc_idx = pick_idx;
  assign avail     = (free_cnt >= CNT_W'(WAYS)) ? AV_W'(WAYS) : AV_W'(free_cnt);

  always_comb begin
    alloc_valid = '0;
    grant_mask  = '0;
    free_mask   = '0;
    new_mask    = '0;
    for (int i = 0; i < WAYS; i++) begin
      // Grants gate on the picker's own count so a lane never claims an index it did not find.
      alloc_valid[i] = alloc_req[i] && (AV_W'(i) < pick_found) && !reset && !flush && !recover_blk;
      if (alloc_valid[i]) grant_mask = grant_mask | onehot(pick_idx[i]);
      if (ret_old_en[i])  free_mask  = free_mask  | onehot(ret_old_idx[i]);
      if (ret_new_en[i])  new_mask   = new_mask   | onehot(ret_new_idx[i]);
    end

    // Applying the frees after the clears lets a free win over a same-cycle map entry.
    com_nxt = (com_free & ~new_mask) | free_mask;

    if (flush)            spec_nxt = com_nxt;
    else if (restore_hit) spec_nxt = restore_vec | free_mask;
    else                  spec_nxt = (spec_free & ~grant_mask) | free_mask;

    cnt_nxt = '0;
    for (int b = 0; b < PRF; b++) cnt_nxt = cnt_nxt + CNT_W'(spec_nxt[b]);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spec_free <= RESET_FREE;
      com_free  <= RESET_FREE;
      free_cnt  <= CNT_W'(PRF - ARF);
    end else begin
      spec_free <= spec_nxt;
      com_free  <= com_nxt;
      free_cnt  <= cnt_nxt;
    end
  end

`ifdef FREELIST_CKPT_EN
  vec_t             snap [NCKPT];
  logic [NCKPT-1:0] snap_vld;
  vec_t             take_vec;
  logic             take_ok;

  assign restore_hit = ckpt_restore && snap_vld[restore_tag];
  assign recover_blk = ckpt_restore;
  assign restore_vec = snap[restore_tag];
  assign take_ok     = ckpt_take && !ckpt_restore && !flush;

  // Lanes older than the branch keep their registers; younger lanes' grants are given back on restore.
  always_comb begin
    take_vec = spec_free;
    for (int i = 0; i < WAYS; i++) begin
      if (alloc_valid[i] && (AV_W'(i) < ckpt_lane)) take_vec = take_vec & ~onehot(pick_idx[i]);
    end
    take_vec = take_vec | free_mask;
  end

  // NOTE: the snapshot payload has no reset; snap_vld gates every use of it.
  always_ff @(posedge clock) begin
    for (int t = 0; t < NCKPT; t++) begin
      if (take_ok && (ckpt_tag == $clog2(NCKPT)'(t))) snap[t] <= take_vec;
      else                                           snap[t] <= snap[t] | free_mask;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)             snap_vld <= '0;
    else if (flush)        snap_vld <= '0;
    else if (ckpt_restore) snap_vld[restore_tag] <= 1'b0;
    else if (ckpt_take)    snap_vld[ckpt_tag]    <= 1'b1;
  end

  restore_needs_valid: assert property (@(posedge clock) disable iff (reset)
    (ckpt_restore && !flush) |-> snap_vld[restore_tag]);
`else
  logic unused_ckpt;

  assign restore_hit = 1'b0;
  assign recover_blk = 1'b0;
  assign restore_vec = '0;
  assign unused_ckpt = ^{ckpt_take, ckpt_tag, ckpt_lane, ckpt_restore, restore_tag};
`endif

  pick_matches_count: assert property (@(posedge clock) disable iff (reset) pick_found == avail);

endmodule

// File: tb/tb_free_list_ckpt.sv
// Bench for free_list_ckpt: directed scenarios plus random traffic against a set-based reference model.
module tb_free_list_ckpt;
  import freelist_pkg::*;

`ifdef FREELIST_CKPT_EN
  localparam bit CKPT = 1'b1;
`else
  localparam bit CKPT = 1'b0;
`endif

  logic                       clock = 1'b0;
  logic                       reset;
  logic [WAYS-1:0]            alloc_req;
  logic [WAYS-1:0][PRF_W-1:0] alloc_idx;
  logic [WAYS-1:0]            alloc_valid;
  logic [AVAIL_W-1:0]         avail;
  logic [WAYS-1:0][PRF_W-1:0] ret_new_idx, ret_old_idx;
  logic [WAYS-1:0]            ret_new_en, ret_old_en;
  logic                       flush, ckpt_take, ckpt_restore;
  ckpt_tag_t                  ckpt_tag, restore_tag;
  logic [AVAIL_W-1:0]         ckpt_lane;

  always #5 clock = ~clock;

  free_list_ckpt dut (
    .clock(clock), .reset(reset),
    .alloc_req(alloc_req), .alloc_idx(alloc_idx), .alloc_valid(alloc_valid), .avail(avail),
    .ret_new_idx(ret_new_idx), .ret_new_en(ret_new_en),
    .ret_old_idx(ret_old_idx), .ret_old_en(ret_old_en),
    .flush(flush), .ckpt_take(ckpt_take), .ckpt_tag(ckpt_tag), .ckpt_lane(ckpt_lane),
    .ckpt_restore(ckpt_restore), .restore_tag(restore_tag)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: free sets as plain bit arrays.
  bit m_spec [PRF];
  bit m_com  [PRF];
  bit m_snap [NCKPT][PRF];
  bit m_vld  [NCKPT];

  logic [WAYS-1:0][PRF_W-1:0] x_idx;
  logic [WAYS-1:0]            x_valid;
  logic [AVAIL_W-1:0]         x_avail;

  function automatic void model_reset();
    for (int r = 0; r < PRF; r++) begin
      m_spec[r] = (r >= ARF);
      m_com[r]  = (r >= ARF);
      for (int t = 0; t < NCKPT; t++) m_snap[t][r] = 1'b0;
    end
    for (int t = 0; t < NCKPT; t++) m_vld[t] = 1'b0;
  endfunction

  function automatic void model_eval();
    int q[$];
    for (int r = 0; r < PRF; r++) if (m_spec[r]) q.push_back(r);
    x_avail = AVAIL_W'((q.size() < WAYS) ? q.size() : WAYS);
    x_idx   = '0;
    x_valid = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (k < q.size()) x_idx[k] = PRF_W'(q[k]);
      x_valid[k] = alloc_req[k] && (k < int'(x_avail)) && !reset && !flush && !(CKPT && ckpt_restore);
    end
  endfunction

  function automatic void model_commit();
    bit frees [PRF];
    bit spec_old [PRF];
    int lane;
    lane = int'(ckpt_lane);
    for (int r = 0; r < PRF; r++) frees[r] = 1'b0;
    for (int i = 0; i < WAYS; i++) if (ret_old_en[i]) frees[ret_old_idx[i]] = 1'b1;
    for (int i = 0; i < WAYS; i++) if (ret_new_en[i]) m_com[ret_new_idx[i]] = 1'b0;
    for (int r = 0; r < PRF; r++) if (frees[r]) m_com[r] = 1'b1;
    spec_old = m_spec;
    if (flush) begin
      m_spec = m_com;
      for (int t = 0; t < NCKPT; t++) m_vld[t] = 1'b0;
    end else if (CKPT && ckpt_restore) begin
      if (m_vld[restore_tag]) begin
        for (int r = 0; r < PRF; r++) m_spec[r] = m_snap[restore_tag][r] | frees[r];
        m_vld[restore_tag] = 1'b0;
      end else begin
        for (int r = 0; r < PRF; r++) m_spec[r] = m_spec[r] | frees[r];
      end
      for (int t = 0; t < NCKPT; t++)
        if (m_vld[t]) for (int r = 0; r < PRF; r++) m_snap[t][r] = m_snap[t][r] | frees[r];
    end else begin
      for (int k = 0; k < WAYS; k++) if (x_valid[k]) m_spec[x_idx[k]] = 1'b0;
      for (int r = 0; r < PRF; r++) m_spec[r] = m_spec[r] | frees[r];
      for (int t = 0; t < NCKPT; t++)
        if (m_vld[t]) for (int r = 0; r < PRF; r++) m_snap[t][r] = m_snap[t][r] | frees[r];
      if (CKPT && ckpt_take) begin
        for (int r = 0; r < PRF; r++) m_snap[ckpt_tag][r] = spec_old[r];
        for (int k = 0; k < WAYS; k++) if (x_valid[k] && k < lane) m_snap[ckpt_tag][x_idx[k]] = 1'b0;
        for (int r = 0; r < PRF; r++) m_snap[ckpt_tag][r] = m_snap[ckpt_tag][r] | frees[r];
        m_vld[ckpt_tag] = 1'b1;
      end
    end
  endfunction

  task automatic idle_inputs();
    alloc_req = '0; ret_new_idx = '0; ret_old_idx = '0; ret_new_en = '0; ret_old_en = '0;
    flush = 1'b0; ckpt_take = 1'b0; ckpt_restore = 1'b0;
    ckpt_tag = '0; restore_tag = '0; ckpt_lane = '0;
  endtask

  // Advance one clock with the model in lockstep; returns at posedge+1.
  task automatic tick();
    model_eval();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [WAYS-1:0][PRF_W-1:0] want;
    idle_inputs();
    reset = 1'b1;
    alloc_req = '1;
    #2;
    for (int k = 0; k < WAYS; k++) want[k] = PRF_W'(ARF + k);
    n_tests++; if (avail !== AVAIL_W'(WAYS)) begin n_fail++; $display("FAIL reset_avail: got %0d want %0d", avail, WAYS); end
    n_tests++; if (alloc_idx !== want) begin n_fail++; $display("FAIL reset_idx: got %h want %h", alloc_idx, want); end
    n_tests++; if (alloc_valid !== '0) begin n_fail++; $display("FAIL reset_valid: got %b want 0000", alloc_valid); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_drain();
    logic [WAYS-1:0][PRF_W-1:0] want;
    do_reset();
    alloc_req = '1;
    for (int c = 0; c < 8; c++) begin
      #2;
      for (int k = 0; k < WAYS; k++) want[k] = PRF_W'(32 + 4 * c + k);
      n_tests++; if (alloc_idx !== want) begin n_fail++; $display("FAIL drain_idx cyc %0d: got %h want %h", c, alloc_idx, want); end
      n_tests++; if (alloc_valid !== 4'b1111) begin n_fail++; $display("FAIL drain_valid cyc %0d: got %b want 1111", c, alloc_valid); end
      tick();
    end
    #2;
    n_tests++; if (avail !== '0) begin n_fail++; $display("FAIL drain_empty_avail: got %0d want 0", avail); end
    n_tests++; if (alloc_valid !== '0) begin n_fail++; $display("FAIL drain_empty_valid: got %b want 0000", alloc_valid); end
    n_tests++; if (alloc_idx !== '0) begin n_fail++; $display("FAIL drain_empty_idx: got %h want 0", alloc_idx); end
  endtask

  // Continues from an empty free list.
  task automatic test_partial_req();
    alloc_req = '0;
    ret_old_en = 4'b0011;
    ret_old_idx[0] = 6'd32;
    ret_old_idx[1] = 6'd33;
    tick();
    ret_old_en = '0;
    alloc_req = 4'b0101;
    #2;
    n_tests++; if (avail !== 3'd2) begin n_fail++; $display("FAIL partial_avail: got %0d want 2", avail); end
    n_tests++; if (alloc_idx[0] !== 6'd32 || alloc_idx[1] !== 6'd33) begin
      n_fail++; $display("FAIL partial_idx: got %0d,%0d want 32,33", alloc_idx[0], alloc_idx[1]); end
    n_tests++; if (alloc_valid !== 4'b0001) begin n_fail++; $display("FAIL partial_valid: got %b want 0001", alloc_valid); end
    tick();
    alloc_req = '0;
    #2;
    n_tests++; if (avail !== 3'd1 || alloc_idx[0] !== 6'd33) begin
      n_fail++; $display("FAIL partial_left: got avail %0d idx %0d want 1 / 33", avail, alloc_idx[0]); end
    alloc_req = 4'b0001;
    tick();
  endtask

  // Continues from an empty free list with committed free set 32..63.
  task automatic test_retire_free();
    logic [WAYS-1:0][PRF_W-1:0] want;
    alloc_req = '1;
    ret_old_en = 4'b0001; ret_old_idx[0] = 6'd5;
    ret_new_en = 4'b0010; ret_new_idx[1] = 6'd5;
    #2;
    n_tests++; if (avail !== '0 || alloc_valid !== '0) begin
      n_fail++; $display("FAIL retire_same_cycle: got avail %0d valid %b want 0 / 0000", avail, alloc_valid); end
    tick();
    idle_inputs();
    #2;
    n_tests++; if (avail !== 3'd1 || alloc_idx[0] !== 6'd5) begin
      n_fail++; $display("FAIL retire_next: got avail %0d idx %0d want 1 / 5", avail, alloc_idx[0]); end
    flush = 1'b1;
    alloc_req = '1;
    #2;
    n_tests++; if (alloc_valid !== '0) begin n_fail++; $display("FAIL retire_flush_grant: got %b want 0000", alloc_valid); end
    tick();
    idle_inputs();
    #2;
    want[0] = 6'd5; want[1] = 6'd32; want[2] = 6'd33; want[3] = 6'd34;
    n_tests++; if (alloc_idx !== want || avail !== 3'd4) begin
      n_fail++; $display("FAIL retire_set_wins: got idx %h avail %0d want %h / 4", alloc_idx, avail, want); end
  endtask

  task automatic test_ckpt_branch();
    do_reset();
    alloc_req = '1;
    ckpt_take = 1'b1; ckpt_tag = 2'd1; ckpt_lane = 3'd2;
    tick();
    ckpt_take = 1'b0;
    tick();
    ckpt_restore = 1'b1; restore_tag = 2'd1;
    #2;
    model_eval();
    n_tests++; if (alloc_valid !== (CKPT ? 4'b0000 : 4'b1111) || alloc_valid !== x_valid) begin
      n_fail++; $display("FAIL ckpt_restore_grant: got %b want %b", alloc_valid, x_valid); end
    tick();
    idle_inputs();
    #2;
    model_eval();
    n_tests++; if (alloc_idx[0] !== (CKPT ? 6'd34 : 6'd44)) begin
      n_fail++; $display("FAIL ckpt_restore_first: got %0d want %0d", alloc_idx[0], CKPT ? 34 : 44); end
    n_tests++; if (alloc_idx !== x_idx || avail !== x_avail) begin
      n_fail++; $display("FAIL ckpt_restore_set: got %h/%0d want %h/%0d", alloc_idx, avail, x_idx, x_avail); end
  endtask

  task automatic test_ckpt_retire();
    do_reset();
    ckpt_take = 1'b1; ckpt_tag = 2'd0; ckpt_lane = 3'd0;
    tick();
    ckpt_take = 1'b0;
    ret_old_en = 4'b0100; ret_old_idx[2] = 6'd7;
    tick();
    ret_old_en = '0;
    alloc_req = '1;
    for (int c = 0; c < 3; c++) tick();
    alloc_req = '0;
    ckpt_restore = 1'b1; restore_tag = 2'd0;
    tick();
    idle_inputs();
    #2;
    n_tests++; if (alloc_idx[0] !== (CKPT ? 6'd7 : 6'd43)) begin
      n_fail++; $display("FAIL ckpt_retire_free: got %0d want %0d", alloc_idx[0], CKPT ? 7 : 43); end
  endtask

  task automatic test_flush();
    logic [WAYS-1:0][PRF_W-1:0] want;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      alloc_req = WAYS'($urandom);
      ckpt_take = 1'($urandom);
      ckpt_tag  = TAG_W'($urandom);
      ckpt_lane = AVAIL_W'($urandom_range(WAYS));
      tick();
    end
    idle_inputs();
    flush = 1'b1;
    alloc_req = '1;
    #2;
    n_tests++; if (alloc_valid !== '0) begin n_fail++; $display("FAIL flush_grant: got %b want 0000", alloc_valid); end
    tick();
    idle_inputs();
    #2;
    for (int k = 0; k < WAYS; k++) want[k] = PRF_W'(32 + k);
    n_tests++; if (alloc_idx !== want || avail !== 3'd4) begin
      n_fail++; $display("FAIL flush_state: got %h/%0d want %h/4", alloc_idx, avail, want); end
    alloc_req = '1;
    ckpt_take = 1'b1; ckpt_tag = 2'd2; ckpt_lane = 3'd0;
    tick();
    idle_inputs();
    ckpt_restore = 1'b1; restore_tag = 2'd2;
    tick();
    idle_inputs();
    #2;
    n_tests++; if (alloc_idx[0] !== (CKPT ? 6'd32 : 6'd36)) begin
      n_fail++; $display("FAIL flush_then_restore: got %0d want %0d", alloc_idx[0], CKPT ? 32 : 36); end
  endtask

  task automatic test_async_reset();
    logic [WAYS-1:0][PRF_W-1:0] want;
    do_reset();
    alloc_req = '1;
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    for (int k = 0; k < WAYS; k++) want[k] = PRF_W'(ARF + k);
    n_tests++; if (alloc_idx !== want || avail !== 3'd4 || alloc_valid !== '0) begin
      n_fail++; $display("FAIL async_reset: got %h/%0d/%b want %h/4/0000", alloc_idx, avail, alloc_valid, want); end
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int cands[$];
      idle_inputs();
      alloc_req = WAYS'($urandom);
      for (int i = 0; i < WAYS; i++) begin
        ret_old_en[i]  = ($urandom_range(3) == 0);
        ret_old_idx[i] = PRF_W'($urandom_range(PRF - 1));
        ret_new_en[i]  = ($urandom_range(3) == 0);
        ret_new_idx[i] = PRF_W'($urandom_range(PRF - 1));
      end
      flush     = ($urandom_range(39) == 0);
      ckpt_take = ($urandom_range(7) == 0);
      ckpt_tag  = TAG_W'($urandom);
      ckpt_lane = AVAIL_W'($urandom_range(WAYS));
      if ($urandom_range(9) == 0) begin
        for (int t = 0; t < NCKPT; t++) if (m_vld[t] || !CKPT) cands.push_back(t);
        if (cands.size() > 0) begin
          ckpt_restore = 1'b1;
          restore_tag  = TAG_W'(cands[$urandom_range(cands.size() - 1)]);
        end
      end
      #2;
      model_eval();
      n_tests++; if (avail !== x_avail) begin n_fail++; $display("FAIL rand_avail cyc %0d: got %0d want %0d", c, avail, x_avail); end
      n_tests++; if (alloc_idx !== x_idx) begin n_fail++; $display("FAIL rand_idx cyc %0d: got %h want %h", c, alloc_idx, x_idx); end
      n_tests++; if (alloc_valid !== x_valid) begin n_fail++; $display("FAIL rand_valid cyc %0d: got %b want %b", c, alloc_valid, x_valid); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    test_reset();
    test_drain();
    test_partial_req();
    test_retire_free();
    test_ckpt_branch();
    test_ckpt_retire();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
